// File: rtl/conv_feeder_pkg.sv
// rtl/conv_feeder_pkg.sv - shared state encoding, default widths and sizing helper for conv_feeder
package conv_feeder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_W,
        ST_W_DRAIN,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int KERNEL_SIZE_DEF = 3;
    localparam int FM_SIZE_DEF     = 5;
    localparam int PADDING_DEF     = 1;
    localparam int FM_W_DEF        = 30;
    localparam int W_W_DEF         = 18;

    // Bits needed to hold 0 .. n-1, never narrower than one bit.
    function automatic int addr_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv_feeder_pad_coord_gen.sv
// rtl/conv_feeder_pad_coord_gen.sv - padded raster (r, c) walker with interior decode and FM address
module pad_coord_gen
    import conv_feeder_pkg::*;
#(
    parameter int FM_SIZE = FM_SIZE_DEF,
    parameter int PADDING = PADDING_DEF,
    parameter int ADDR_W  = addr_w(FM_SIZE * FM_SIZE)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear,
    input  logic              i_adv,
    output logic              o_first,
    output logic              o_last,
    output logic              o_interior,
    output logic [ADDR_W-1:0] o_addr
);

    localparam int S   = FM_SIZE + 2 * PADDING;
    localparam int R_W = addr_w(S);
    localparam logic [R_W-1:0] S_M1 = R_W'(S - 1);

    logic [R_W-1:0] r_q, c_q;
    logic [R_W-1:0] r_off, c_off;
    logic           r_in, c_in;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q <= '0;
            c_q <= '0;
        end else if (i_clear) begin
            r_q <= '0;
            c_q <= '0;
        end else if (i_adv) begin
            if (c_q == S_M1) begin
                c_q <= '0;
                if (r_q != S_M1) begin
                    r_q <= r_q + 1'b1;
                end
            end else begin
                c_q <= c_q + 1'b1;
            end
        end
    end

    // Without padding every coordinate is interior; skip the comparisons entirely.
    generate
        if (PADDING == 0) begin : g_nopad
            assign r_in = 1'b1;
            assign c_in = 1'b1;
        end else begin : g_pad
            localparam logic [R_W-1:0] LO = R_W'(PADDING);
            localparam logic [R_W-1:0] HI = R_W'(FM_SIZE + PADDING - 1);
            assign r_in = (r_q >= LO) && (r_q <= HI);
            assign c_in = (c_q >= LO) && (c_q <= HI);
        end
    endgenerate

    assign r_off      = r_q - R_W'(PADDING);
    assign c_off      = c_q - R_W'(PADDING);
    assign o_addr     = ADDR_W'(r_off) * ADDR_W'(FM_SIZE) + ADDR_W'(c_off);
    assign o_interior = r_in && c_in;
    assign o_first    = (r_q == '0) && (c_q == '0);
    assign o_last     = (r_q == S_M1) && (c_q == S_M1);

endmodule

// File: rtl/conv_feeder.sv
// rtl/conv_feeder.sv - loads one kernel's weights then streams the zero-padded FM; CONV_FEEDER_STALL_EN adds i_stall
module conv_feeder
    import conv_feeder_pkg::*;
#(
    parameter int KERNEL_SIZE = KERNEL_SIZE_DEF,
    parameter int FM_SIZE     = FM_SIZE_DEF,
    parameter int PADDING     = PADDING_DEF,
    parameter int FM_W        = FM_W_DEF,
    parameter int W_W         = W_W_DEF,
    localparam int KK         = KERNEL_SIZE * KERNEL_SIZE,
    localparam int WA_W       = addr_w(KK),
    localparam int FA_W       = addr_w(FM_SIZE * FM_SIZE)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_go,
    output logic             o_w_en,
    output logic [WA_W-1:0]  o_w_addr,
    input  logic [W_W-1:0]   i_w_data,
    output logic             o_fm_en,
    output logic [FA_W-1:0]  o_fm_addr,
    input  logic [FM_W-1:0]  i_fm_data,
    output logic [KK*W_W-1:0] o_weight_data,
    output logic [FM_W-1:0]  o_fm_data,
    output logic             o_fm_valid,
    output logic             o_conv_go,
    output logic             o_done
`ifdef CONV_FEEDER_STALL_EN
    ,
    input  logic             i_stall
`endif
);

    localparam logic [WA_W-1:0] W_LAST = WA_W'(KK - 1);

    state_t state_q, state_d;

    logic [WA_W-1:0]   w_cnt_q;
    logic [WA_W-1:0]   w_slot_q;
    logic              w_cap_q;
    logic [KK*W_W-1:0] weight_q;
    logic              pix_valid_q, pad_q, first_q;
    logic              issue, stall;
    logic              cg_clear, cg_adv, cg_first, cg_last, cg_interior;
    logic [FA_W-1:0]   cg_addr;

`ifdef CONV_FEEDER_STALL_EN
    assign stall = i_stall;
`else
    assign stall = 1'b0;
`endif

    pad_coord_gen #(
        .FM_SIZE (FM_SIZE),
        .PADDING (PADDING),
        .ADDR_W  (FA_W)
    ) u_coord (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clear    (cg_clear),
        .i_adv      (cg_adv),
        .o_first    (cg_first),
        .o_last     (cg_last),
        .o_interior (cg_interior),
        .o_addr     (cg_addr)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        o_w_en   = 1'b0;
        cg_clear = 1'b0;
        cg_adv   = 1'b0;
        issue    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_go) begin
                    state_d = ST_LOAD_W;
                end
            end
            ST_LOAD_W: begin
                o_w_en = 1'b1;
                if (w_cnt_q == W_LAST) begin
                    state_d = ST_W_DRAIN;
                end
            end
            ST_W_DRAIN: begin
                cg_clear = 1'b1;
                state_d  = ST_STREAM;
            end
            ST_STREAM: begin
                if (!stall) begin
                    issue  = 1'b1;
                    cg_adv = 1'b1;
                    if (cg_last) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Weight read data lags its address by one cycle, so capture into the slot of last cycle's address.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            w_cnt_q  <= '0;
            w_slot_q <= '0;
            w_cap_q  <= 1'b0;
            weight_q <= '0;
        end else begin
            if (state_q == ST_IDLE) begin
                w_cnt_q <= '0;
            end else if (state_q == ST_LOAD_W && w_cnt_q != W_LAST) begin
                w_cnt_q <= w_cnt_q + 1'b1;
            end
            w_cap_q  <= o_w_en;
            w_slot_q <= w_cnt_q;
            if (w_cap_q) begin
                weight_q[w_slot_q*W_W +: W_W] <= i_w_data;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pix_valid_q <= 1'b0;
            pad_q       <= 1'b0;
            first_q     <= 1'b0;
        end else begin
            pix_valid_q <= issue;
            pad_q       <= ~cg_interior;
            first_q     <= issue && cg_first;
        end
    end

    assign o_w_addr      = o_w_en ? w_cnt_q : '0;
    assign o_fm_en       = issue && cg_interior;
    assign o_fm_addr     = o_fm_en ? cg_addr : '0;
    assign o_weight_data = weight_q;
    assign o_fm_data     = (pix_valid_q && !pad_q) ? i_fm_data : '0;
    assign o_fm_valid    = pix_valid_q;
    assign o_conv_go     = first_q;
    assign o_done        = (state_q == ST_DONE);

endmodule
